// File: rtl/rgb_de_capture_if.sv
// rtl/rgb_de_capture_if.sv - DE-mode RGB666 input and frame-buffer write port bundle
//
// Groups the parallel video input with the frame-buffer write port.
//   master : video source / frame-buffer side (drives vid_*, receives wr_*)
//   slave  : capture block (receives vid_*, drives wr_*)
// Signals:
//   vid_de            data enable
//   vid_r/vid_g/vid_b 6-bit colour components
//   wr_en             frame-buffer write strobe
//   wr_addr           pixel address, y*H_ACTIVE+x
//   wr_data           RGB565 pixel
interface rgb_de_capture_if #(
   parameter int ADDR_W = 19
);
   logic              vid_de;
   logic [5:0]        vid_r;
   logic [5:0]        vid_g;
   logic [5:0]        vid_b;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [15:0]       wr_data;

   modport master (
      output vid_de, vid_r, vid_g, vid_b,
      input  wr_en, wr_addr, wr_data
   );

   modport slave (
      input  vid_de, vid_r, vid_g, vid_b,
      output wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/rgb_de_capture.sv
// rtl/rgb_de_capture.sv - DE-mode RGB666 capture with geometry measurement
//
// Samples DE-only parallel video, finds frame boundaries from the length of
// DE-low gaps, converts pixels to RGB565 and issues row-major frame-buffer
// writes. Measures line width / frame height and reports lock and errors.
// Ports:
//   clk          pixel clock, rising edge
//   rst          synchronous reset, active-high
//   capture_en   enables writes for a frame, sampled at frame start
//   bus          slave side of rgb_de_capture_if (vid_* in, wr_* out)
//   frame_start  one-cycle pulse on the first pixel of a frame
//   frame_done   one-cycle pulse when vertical blanking is recognised
//   meas_width   DE run length of the last line (saturating)
//   meas_height  line count of the last frame (saturating)
//   locked       last frame was exactly H_ACTIVE x V_ACTIVE
//   err          one-cycle pulse on a geometry violation
module rgb_de_capture #(
   parameter int H_ACTIVE   = 800,
   parameter int V_ACTIVE   = 480,
   parameter int VBLANK_MIN = 2048,
   parameter int ADDR_W     = 19
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              capture_en,
   rgb_de_capture_if.slave   bus,
   output logic              frame_start,
   output logic              frame_done,
   output logic [11:0]       meas_width,
   output logic [11:0]       meas_height,
   output logic              locked,
   output logic              err
);

   localparam int                GAP_W    = $clog2(VBLANK_MIN + 1);
   localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(VBLANK_MIN);
   localparam logic [11:0]       H_W      = 12'(H_ACTIVE);
   localparam logic [11:0]       V_H      = 12'(V_ACTIVE);
   localparam logic [11:0]       SAT12    = 12'hFFF;
   localparam logic [ADDR_W-1:0] H_STRIDE = ADDR_W'(H_ACTIVE);

   typedef enum logic [1:0] {
      SEARCH,
      WAIT_FRAME,
      LINE,
      HBLANK
   } state_t;

   state_t state, state_nxt;

   // stage s1: registered video input
   logic       s1_de;
   logic [5:0] s1_r, s1_g, s1_b;

   logic [GAP_W-1:0]  gap, gap_nxt;
   logic [11:0]       x, x_nxt;
   logic [11:0]       y, y_nxt;
   logic [11:0]       run, run_nxt;
   logic [ADDR_W-1:0] addr, addr_nxt;
   logic [ADDR_W-1:0] row_base, row_base_nxt;
   logic              cap_act, cap_act_nxt;
   logic              frame_bad, frame_bad_nxt;

   // stage s2: output registers
   logic              wr_en_q, wr_en_nxt;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_nxt;
   logic [15:0]       wr_data_q, wr_data_nxt;
   logic              frame_start_nxt, frame_done_nxt, err_nxt, locked_nxt;
   logic [11:0]       meas_width_nxt, meas_height_nxt;

   logic              vblank;
   logic              pix;

   // RGB565 drops the colour LSBs of red and blue
   wire unused_lsbs = s1_r[0] ^ s1_b[0];

   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;

   always_comb begin
      state_nxt       = state;
      gap_nxt         = gap;
      x_nxt           = x;
      y_nxt           = y;
      run_nxt         = run;
      addr_nxt        = addr;
      row_base_nxt    = row_base;
      cap_act_nxt     = cap_act;
      frame_bad_nxt   = frame_bad;
      wr_en_nxt       = 1'b0;
      wr_addr_nxt     = wr_addr_q;
      wr_data_nxt     = wr_data_q;
      frame_start_nxt = 1'b0;
      frame_done_nxt  = 1'b0;
      err_nxt         = 1'b0;
      locked_nxt      = locked;
      meas_width_nxt  = meas_width;
      meas_height_nxt = meas_height;
      pix             = 1'b0;

      if (s1_de) begin
         gap_nxt = '0;
      end else if (gap != GAP_MAX) begin
         gap_nxt = gap + GAP_W'(1);
      end
      // Qualified by DE low so a DE rise right after a full gap is never
      // swallowed by the blanking decision.
      vblank = !s1_de && (gap_nxt == GAP_MAX);

      case (state)
         SEARCH: begin
            if (vblank) begin
               state_nxt = WAIT_FRAME;
            end
         end
         WAIT_FRAME: begin
            // only entered on a DE-low cycle, so DE high here is a rising edge
            if (s1_de) begin
               frame_start_nxt = 1'b1;
               x_nxt           = '0;
               y_nxt           = '0;
               run_nxt         = '0;
               addr_nxt        = '0;
               row_base_nxt    = '0;
               cap_act_nxt     = capture_en;
               frame_bad_nxt   = 1'b0;
               pix             = 1'b1;
               state_nxt       = LINE;
            end
         end
         LINE: begin
            if (s1_de) begin
               pix = 1'b1;
            end else begin
               meas_width_nxt = run;
               if (run != H_W) begin
                  err_nxt       = 1'b1;
                  frame_bad_nxt = 1'b1;
               end
               if (y != SAT12) begin
                  y_nxt = y + 12'd1;
               end
               x_nxt        = '0;
               run_nxt      = '0;
               // rebase on the row stride so long/short lines never skew rows
               row_base_nxt = row_base + H_STRIDE;
               addr_nxt     = row_base + H_STRIDE;
               state_nxt    = HBLANK;
            end
         end
         HBLANK: begin
            if (vblank) begin
               meas_height_nxt = y;
               if (y != V_H) begin
                  err_nxt = 1'b1;
               end
               frame_done_nxt = 1'b1;
               locked_nxt     = !frame_bad && (y == V_H);
               frame_bad_nxt  = 1'b0;
               state_nxt      = WAIT_FRAME;
            end else if (s1_de) begin
               pix       = 1'b1;
               state_nxt = LINE;
            end
         end
         default: state_nxt = SEARCH;
      endcase

      // pixel accept uses the already-updated x/y/addr so the first pixel of
      // a frame or line is handled in the same cycle as the DE rise
      if (pix) begin
         if (run_nxt != SAT12) begin
            run_nxt = run_nxt + 12'd1;
         end
         if ((x_nxt < H_W) && (y_nxt < V_H) && cap_act_nxt) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = addr_nxt;
            wr_data_nxt = {s1_r[5:1], s1_g, s1_b[5:1]};
            x_nxt       = x_nxt + 12'd1;
            addr_nxt    = addr_nxt + ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= SEARCH;
         s1_de       <= 1'b0;
         s1_r        <= '0;
         s1_g        <= '0;
         s1_b        <= '0;
         gap         <= '0;
         x           <= '0;
         y           <= '0;
         run         <= '0;
         addr        <= '0;
         row_base    <= '0;
         cap_act     <= 1'b0;
         frame_bad   <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         meas_width  <= '0;
         meas_height <= '0;
         locked      <= 1'b0;
         err         <= 1'b0;
      end else begin
         state       <= state_nxt;
         s1_de       <= bus.vid_de;
         s1_r        <= bus.vid_r;
         s1_g        <= bus.vid_g;
         s1_b        <= bus.vid_b;
         gap         <= gap_nxt;
         x           <= x_nxt;
         y           <= y_nxt;
         run         <= run_nxt;
         addr        <= addr_nxt;
         row_base    <= row_base_nxt;
         cap_act     <= cap_act_nxt;
         frame_bad   <= frame_bad_nxt;
         wr_en_q     <= wr_en_nxt;
         wr_addr_q   <= wr_addr_nxt;
         wr_data_q   <= wr_data_nxt;
         frame_start <= frame_start_nxt;
         frame_done  <= frame_done_nxt;
         meas_width  <= meas_width_nxt;
         meas_height <= meas_height_nxt;
         locked      <= locked_nxt;
         err         <= err_nxt;
      end
   end

endmodule

// File: tb/tb_rgb_de_capture.sv
// tb/tb_rgb_de_capture.sv - self-checking bench for rgb_de_capture
module tb_rgb_de_capture;

   localparam int H_TB  = 8;
   localparam int V_TB  = 4;
   localparam int VBMIN = 24;
   localparam int AW    = 19;
   localparam int HB    = 6;
   localparam int VB    = 32;

   typedef struct {
      logic [AW-1:0] addr;
      logic [15:0]   data;
   } wr_t;

   typedef struct {
      bit cap;
      bit fixed;
      int nlines;
      int odd_line;
      int odd_len;
      int raise_line;
      int exp_wr;
      int exp_w;
      int exp_h;
      bit exp_lock;
      int exp_err;
      int exp_err_done;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        capture_en;
   logic        frame_start, frame_done, locked, err;
   logic [11:0] meas_width, meas_height;

   rgb_de_capture_if #(.ADDR_W(AW)) bus ();

   rgb_de_capture #(
      .H_ACTIVE   (H_TB),
      .V_ACTIVE   (V_TB),
      .VBLANK_MIN (VBMIN),
      .ADDR_W     (AW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .capture_en  (capture_en),
      .bus         (bus),
      .frame_start (frame_start),
      .frame_done  (frame_done),
      .meas_width  (meas_width),
      .meas_height (meas_height),
      .locked      (locked),
      .err         (err)
   );

   always #5 clk = ~clk;

   int  tests = 0;
   int  fails = 0;
   int  cyc = 0;
   int  fs_cnt, fd_cnt, err_cnt, err_done_cnt, wr_cnt;
   int  first_wr_cyc, drv_first_cyc;
   wr_t sb[$];
   vec_t tbl[10];

   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard monitor, sampled away from the active edge
   always @(negedge clk) begin
      wr_t e;
      if (frame_start) fs_cnt++;
      if (frame_done) fd_cnt++;
      if (err) begin
         err_cnt++;
         if (frame_done) err_done_cnt++;
      end
      if (bus.wr_en) begin
         wr_cnt++;
         if (first_wr_cyc < 0) first_wr_cyc = cyc;
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write: got addr %0d data %h, required no write", bus.wr_addr, bus.wr_data);
         end else begin
            e = sb.pop_front();
            if (bus.wr_addr != e.addr || bus.wr_data != e.data) begin
               fails++;
               $display("FAIL write: got addr %0d data %h, required addr %0d data %h",
                        bus.wr_addr, bus.wr_data, e.addr, e.data);
            end
         end
      end
   end

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic clr_counts();
      fs_cnt = 0; fd_cnt = 0; err_cnt = 0; err_done_cnt = 0; wr_cnt = 0;
      first_wr_cyc = -1; drv_first_cyc = -1;
   endtask

   task automatic tick(input logic de, input logic [5:0] r, input logic [5:0] g, input logic [5:0] b);
      bus.vid_de = de;
      bus.vid_r  = r;
      bus.vid_g  = g;
      bus.vid_b  = b;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_line(input int len, input int row, input bit push, input bit fixed);
      for (int i = 0; i < len; i++) begin
         logic [5:0] r, g, b;
         wr_t e;
         if (fixed) begin
            r = 6'h3F; g = 6'h15; b = 6'h01;
         end else begin
            r = 6'($urandom); g = 6'($urandom); b = 6'($urandom);
         end
         if (push && i < H_TB && row < V_TB) begin
            e.addr = AW'(row * H_TB + i);
            e.data = fixed ? 16'hFAA0 : {r[5:1], g, b[5:1]};
            sb.push_back(e);
         end
         if (drv_first_cyc < 0) drv_first_cyc = cyc;
         tick(1'b1, r, g, b);
      end
      for (int i = 0; i < HB; i++) tick(1'b0, 6'd0, 6'd0, 6'd0);
   endtask

   task automatic run_frame(input vec_t v);
      clr_counts();
      capture_en = v.cap;
      for (int l = 0; l < v.nlines; l++) begin
         if (l == v.raise_line) capture_en = 1'b1;
         drive_line((l == v.odd_line) ? v.odd_len : H_TB, l, v.cap, v.fixed);
      end
      for (int i = 0; i < VB; i++) tick(1'b0, 6'd0, 6'd0, 6'd0);
      chk("frame_start_pulses", fs_cnt, 1);
      chk("frame_done_pulses", fd_cnt, 1);
      chk("writes", wr_cnt, v.exp_wr);
      chk("meas_width", meas_width, v.exp_w);
      chk("meas_height", meas_height, v.exp_h);
      chk("locked", locked, v.exp_lock);
      chk("err_pulses", err_cnt, v.exp_err);
      chk("err_with_done", err_done_cnt, v.exp_err_done);
      chk("scoreboard_drained", sb.size(), 0);
      if (v.exp_wr > 0) chk("latency", first_wr_cyc - drv_first_cyc, 2);
   endtask

   initial begin
      //          cap fix n  odd len raise wr  w   h  lk err ed
      tbl[0] = '{1, 1, 4, -1, 8,  -1,  32, 8,  4, 1, 0, 0};  // standard, fixed colour
      tbl[1] = '{1, 0, 4,  1, 10, -1,  32, 8,  4, 0, 1, 0};  // long line 1
      tbl[2] = '{1, 0, 4, -1, 8,  -1,  32, 8,  4, 1, 0, 0};  // good frame
      tbl[3] = '{1, 0, 3, -1, 8,  -1,  24, 8,  3, 0, 1, 1};  // short frame
      tbl[4] = '{1, 0, 4, -1, 8,  -1,  32, 8,  4, 1, 0, 0};  // lock restored
      tbl[5] = '{0, 0, 4, -1, 8,   2,   0, 8,  4, 1, 0, 0};  // capture off, raised mid-frame
      tbl[6] = '{1, 0, 4, -1, 8,  -1,  32, 8,  4, 1, 0, 0};  // next frame captured
      tbl[7] = '{1, 0, 4,  2, 5,  -1,  29, 8,  4, 0, 1, 0};  // short line 2
      tbl[8] = '{1, 0, 6, -1, 8,  -1,  32, 8,  6, 0, 1, 1};  // too many lines
      tbl[9] = '{1, 0, 4,  3, 12, -1,  32, 12, 4, 0, 1, 0};  // long last line

      clr_counts();
      rst = 1'b1;
      capture_en = 1'b0;
      for (int i = 0; i < 3; i++) tick(1'b0, 6'd0, 6'd0, 6'd0);
      chk("reset_wr_en", bus.wr_en, 0);
      chk("reset_wr_addr", bus.wr_addr, 0);
      chk("reset_wr_data", bus.wr_data, 0);
      chk("reset_locked", locked, 0);
      chk("reset_err", err, 0);
      chk("reset_meas_width", meas_width, 0);
      chk("reset_meas_height", meas_height, 0);
      rst = 1'b0;
      for (int i = 0; i < 40; i++) tick(1'b0, 6'd0, 6'd0, 6'd0);

      for (int k = 0; k < 10; k++) run_frame(tbl[k]);

      // reset in the middle of a frame
      run_frame(tbl[2]);
      clr_counts();
      capture_en = 1'b1;
      drive_line(H_TB, 0, 1'b1, 1'b0);
      drive_line(H_TB, 1, 1'b1, 1'b0);
      chk("pre_reset_writes", wr_cnt, 2 * H_TB);
      rst = 1'b1;
      tick(1'b0, 6'd0, 6'd0, 6'd0);
      rst = 1'b0;
      chk("midreset_locked", locked, 0);
      chk("midreset_meas_width", meas_width, 0);
      chk("midreset_meas_height", meas_height, 0);
      clr_counts();
      for (int l = 2; l < 6; l++) drive_line(H_TB, l, 1'b0, 1'b0);
      chk("search_writes", wr_cnt, 0);
      chk("search_frame_start", fs_cnt, 0);
      chk("search_frame_done", fd_cnt, 0);
      for (int i = 0; i < 40; i++) tick(1'b0, 6'd0, 6'd0, 6'd0);
      run_frame(tbl[0]);

      chk("scoreboard_final", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
